// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-limited sequential fetch, DEPTH-entry response queue, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module if_fetch_queue #(
  parameter int              N        = 32,
  parameter int              DEPTH    = 4,
  parameter logic [N-1:0]    RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         id_valid,
  input  logic         id_ready,
  output logic [N-1:0] id_inst,
  output logic [N-1:0] id_pc,
  output logic [N-1:0] id_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [N-1:0]  STEP    = N'(4);

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          req_q, req_d;

  logic [N-1:0]  inst_mem [DEPTH];
  logic [N-1:0]  pc_mem   [DEPTH];

  logic          grant;
  logic          resp_live;
  logic          q_valid;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          consume_direct;
  logic [N-1:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~N'(3);
  assign grant            = req_q & imem_gnt;
  // A response is new-stream only when nothing is left to drop and no redirect kills it this cycle.
  assign resp_live        = imem_rvalid & (drop_q == '0) & ~redirect;
  assign q_valid          = (count_q != '0);
  assign pop              = q_valid & id_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass           = resp_live & ~q_valid;
`else
  assign bypass           = 1'b0;
`endif
  assign consume_direct   = bypass & id_ready;
  assign push             = resp_live & ~consume_direct;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;

    if (grant && !imem_rvalid) begin
      if (outstanding_q != DEPTH_C) outstanding_d = outstanding_q + CW'(1);
    end else if (!grant && imem_rvalid) begin
      if (outstanding_q != '0) outstanding_d = outstanding_q - CW'(1);
    end

    if (redirect) begin
      // Everything still in flight belongs to the old stream, including a grant made this cycle.
      drop_d     = outstanding_d;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
    end else begin
      if (imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (grant) fetch_pc_d = fetch_pc_q + STEP;
      if (resp_live) resp_pc_d = resp_pc_q + STEP;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop) begin
        if (count_q != DEPTH_C) count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end

    req_d = ({1'b0, count_d} + {1'b0, outstanding_d}) < {1'b0, DEPTH_C};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      req_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      req_q         <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]   <= resp_pc_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
  assign id_valid = q_valid | bypass;
  assign id_inst  = q_valid ? inst_mem[head_q] : (bypass ? imem_rdata : '0);
  assign id_pc    = q_valid ? pc_mem[head_q]   : (bypass ? resp_pc_q  : '0);
`else
  assign id_valid = q_valid;
  assign id_inst  = q_valid ? inst_mem[head_q] : '0;
  assign id_pc    = q_valid ? pc_mem[head_q]   : '0;
`endif
  assign id_pc_plus4 = id_valid ? (id_pc + STEP) : '0;

endmodule
